// File: rtl/alu_16bit.sv
// 16-bit ALU (ADD/SUB/AND/OR) with registered result and NZCV flags.
module alu_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ALU_CTRL,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] ALU_OUT,
  output logic        N,
  output logic        Z,
  output logic        C,
  output logic        V
);

  localparam int unsigned DW = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic          is_sub;
  logic [DW-1:0] b_op;
  logic [DW:0]   sum;
  logic [DW-1:0] res_c;
  logic          c_c;
  logic          v_c;

  // Shared adder: SUB reuses it as A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    is_sub = (ALU_CTRL == OP_SUB);
    b_op   = is_sub ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_op} + (DW+1)'(is_sub);
  end

  // Result and carry/overflow selection per operation.
  always_comb begin
    res_c = sum[DW-1:0];
    c_c   = 1'b0;
    v_c   = 1'b0;
    unique case (ALU_CTRL)
      OP_ADD: begin
        res_c = sum[DW-1:0];
        c_c   = sum[DW];
        v_c   = (A[DW-1] == B[DW-1]) && (sum[DW-1] != A[DW-1]);
      end
      OP_SUB: begin
        res_c = sum[DW-1:0];
        c_c   = sum[DW];
        v_c   = (A[DW-1] != B[DW-1]) && (sum[DW-1] != A[DW-1]);
      end
      OP_AND: res_c = A & B;
      OP_OR:  res_c = A | B;
      default: res_c = sum[DW-1:0];
    endcase
  end

  // Output register; reset clears everything, including Z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_OUT <= '0;
      N       <= 1'b0;
      Z       <= 1'b0;
      C       <= 1'b0;
      V       <= 1'b0;
    end else begin
      ALU_OUT <= res_c;
      N       <= res_c[DW-1];
      Z       <= (res_c == '0);
      C       <= c_c;
      V       <= v_c;
    end
  end

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed plan plus randomized ops vs an integer model.
module tb_alu_16bit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ALU_CTRL;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] ALU_OUT;
  logic        N, Z, C, V;

  int checks;
  int errors;

  alu_16bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ALU_CTRL (ALU_CTRL),
    .A        (A),
    .B        (B),
    .ALU_OUT  (ALU_OUT),
    .N        (N),
    .Z        (Z),
    .C        (C),
    .V        (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, packed as {result, N, Z, C, V}.
  function automatic logic [19:0] model(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int ua, ub, sa, sb, u, s;
    logic [15:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        u = ua + ub;
        s = sa + sb;
        r = u[15:0];
        c = (u > 65535);
        v = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        u = ua - ub;
        s = sa - sb;
        r = u[15:0];
        c = (ua >= ub);
        v = (s > 32767) || (s < -32768);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r, r[15], (r == 16'h0000), c, v};
  endfunction

  task automatic check(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = {ALU_OUT, N, Z, C, V};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed out=%h nzcv=%b expected out=%h nzcv=%b",
             tag, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  // Drive one op between edges, then check just after the capturing edge.
  task automatic apply(input string tag, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    ALU_CTRL = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check(tag, model(op, a, b));
  endtask

  initial begin
    logic [19:0] held;
    logic [1:0]  rop;
    logic [15:0] ra, rb;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ALU_CTRL = 2'd0;
    A = 16'h0000;
    B = 16'h0000;
    #1;
    check("reset_initial", 20'h0_0000);

    @(negedge clk);
    rst_n = 1'b1;

    // Reset behaviour
    apply("rst_pre_add", 2'd0, 16'hFFFF, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", 20'h0_0000);
    @(posedge clk);
    #1;
    check("rst_hold_over_edge", 20'h0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_first_edge", {16'h0000, 4'b0110});

    // ADD
    apply("add_0_0",       2'd0, 16'h0000, 16'h0000);
    apply("add_0_ffff",    2'd0, 16'h0000, 16'hFFFF);
    apply("add_0625_0725", 2'd0, 16'h0625, 16'h0725);
    apply("add_7fff_1",    2'd0, 16'h7FFF, 16'h0001);
    // SUB
    apply("sub_1_1",       2'd1, 16'h0001, 16'h0001);
    apply("sub_1_0",       2'd1, 16'h0001, 16'h0000);
    apply("sub_0_1",       2'd1, 16'h0000, 16'h0001);
    apply("sub_8000_1",    2'd1, 16'h8000, 16'h0001);
    // AND / OR
    apply("and_0f0f_00ff", 2'd2, 16'h0F0F, 16'h00FF);
    apply("and_ffff_ffff", 2'd2, 16'hFFFF, 16'hFFFF);
    apply("or_0f0f_00ff",  2'd3, 16'h0F0F, 16'h00FF);
    apply("or_ff00_00ff",  2'd3, 16'hFF00, 16'h00FF);

    // Constants cross-checked against hand-derived plan values
    apply("plan_add_ovf",  2'd0, 16'h7FFF, 16'h0001);
    check("plan_add_ovf_const", {16'h8000, 4'b1001});
    apply("plan_sub_ovf",  2'd1, 16'h8000, 16'h0001);
    check("plan_sub_ovf_const", {16'h7FFF, 4'b0011});

    // Mid-cycle input changes must not disturb registered outputs
    held = {ALU_OUT, N, Z, C, V};
    #2;
    ALU_CTRL = 2'd0;
    A = 16'h1234;
    B = 16'hFFFF;
    #1;
    check("midcycle_hold_a", held);
    A = 16'h0000;
    B = 16'h0000;
    #1;
    check("midcycle_hold_b", held);

    // Back-to-back randomized issue, one op per cycle, with mid-cycle toggles
    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i % 7 == 0) ra = 16'h8000;
      if (i % 11 == 0) rb = ra;
      apply($sformatf("rand_%0d", i), rop, ra, rb);
      if (i % 5 == 0) begin
        #1;
        A = ~A;
        B = 16'($urandom);
        #1;
        check($sformatf("rand_hold_%0d", i), model(rop, ra, rb));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
